branch_flag_ctrl: RTL and testbench

- Sequences condition-flag updates and conditional-branch resolution for the CS552 pipeline.
- Owns the architectural Z/V/N flag state and counts flag-writing instructions still in flight.
- Accepts one branch at a time from decode and stalls it until all older flag writers have retired.
- Evaluates the 4-bit condition code, then issues a redirect plus a fixed-length flush when the branch is taken.

---
 rtl/branch_flag_ctrl_pkg.sv | 22 ++
 rtl/branch_flag_ctrl_cond_eval.sv | 33 +++
 rtl/branch_flag_ctrl.sv | 169 ++++++++++++++++
 tb/tb_branch_flag_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_flag_ctrl_pkg.sv
// Shared encodings for the branch/flag controller: condition codes and FSM states.
package branch_flag_ctrl_pkg;

    // Condition codes, low three bits of br_cond; bit 3 is ignored.
    localparam logic [2:0] COND_EQ  = 3'b000;  // z
    localparam logic [2:0] COND_NE  = 3'b001;  // ~z
    localparam logic [2:0] COND_GT  = 3'b010;  // ~z & ~n & ~v
    localparam logic [2:0] COND_LT  = 3'b011;  // n & ~v
    localparam logic [2:0] COND_GE  = 3'b100;  // ~n & ~v
    localparam logic [2:0] COND_LE  = 3'b101;  // (n & ~v) | z
    localparam logic [2:0] COND_OV  = 3'b110;  // v
    localparam logic [2:0] COND_ALW = 3'b111;  // always

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EVAL  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/branch_flag_ctrl_cond_eval.sv
// Combinational condition evaluator: decides taken/not-taken from a 4-bit
// condition code and the Z/V/N flags. Bit 3 of the code is a don't-care.
module cond_eval
    import branch_flag_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       z,
    input  logic       v,
    input  logic       n,
    output logic       taken
);

    // Bit 3 carries no meaning for condition selection.
    logic unused_cond_hi;
    assign unused_cond_hi = cond[3];

    // Decode the low three bits of the condition code against the flags.
    always_comb begin
        taken = 1'b0;
        case (cond[2:0])
            COND_EQ:  taken = z;
            COND_NE:  taken = ~z;
            COND_GT:  taken = ~z & ~n & ~v;
            COND_LT:  taken = n & ~v;
            COND_GE:  taken = ~n & ~v;
            COND_LE:  taken = (n & ~v) | z;
            COND_OV:  taken = v;
            COND_ALW: taken = 1'b1;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_flag_ctrl.sv
// Branch/flag controller: owns the Z/V/N flags, counts in-flight flag
// writers, holds one branch until older writers retire, resolves it, and
// issues a redirect plus fixed-length flush when taken.
module branch_flag_ctrl
    import branch_flag_ctrl_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int MAX_PEND  = 3,
    parameter int FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flag_wr_issue,
    input  logic            flag_wr_valid,
    input  logic            nxt_z,
    input  logic            nxt_v,
    input  logic            nxt_n,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [3:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            br_resolved,
    output logic            br_taken,
    output logic            stall,
    output logic            flush,
    output logic            err
);

    localparam int CNT_W = $clog2(MAX_PEND + 1);

    state_t          state, state_nxt;
    logic [CNT_W-1:0] pending, pending_nxt;
    logic            pend_err;
    logic            z, v, n;
    logic            z_nxt, v_nxt, n_nxt;
    logic [3:0]      cond_q, cond_nxt;
    logic [PC_W-1:0] target_q, target_nxt;
    logic [2:0]      flush_cnt;
    logic            eval_taken;

    // Next pending count; overflow and underflow are flagged, count saturates.
    always_comb begin
        pending_nxt = pending;
        pend_err    = 1'b0;
        case ({flag_wr_issue, flag_wr_valid})
            2'b10: begin
                if (pending == CNT_W'(MAX_PEND)) pend_err = 1'b1;
                else                             pending_nxt = pending + 1'b1;
            end
            2'b01: begin
                if (pending == '0) pend_err = 1'b1;
                else               pending_nxt = pending - 1'b1;
            end
            default: pending_nxt = pending;
        endcase
    end

    // Flags as they will be after this edge; a retiring writer always loads.
    always_comb begin
        z_nxt = z;
        v_nxt = v;
        n_nxt = n;
        if (flag_wr_valid) begin
            z_nxt = nxt_z;
            v_nxt = nxt_v;
            n_nxt = nxt_n;
        end
    end

    // Next-state logic plus the state-decoded handshake outputs.
    always_comb begin
        state_nxt  = state;
        cond_nxt   = cond_q;
        target_nxt = target_q;
        br_ready   = 1'b0;
        stall      = 1'b1;
        case (state)
            ST_IDLE: begin
                br_ready = 1'b1;
                stall    = 1'b0;
                if (br_valid) begin
                    cond_nxt   = br_cond;
                    target_nxt = br_target;
                    state_nxt  = (pending_nxt == '0) ? ST_EVAL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Leave on the edge the last older writer retires, so EVAL
                // sees its flags already registered.
                if (pending_nxt == '0) state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                state_nxt = br_taken ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                if (flush_cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The evaluator looks at the condition and flags that EVAL will hold, so
    // the registered outcome lines up with the EVAL cycle.
    cond_eval u_cond_eval (
        .cond  (cond_nxt),
        .z     (z_nxt),
        .v     (v_nxt),
        .n     (n_nxt),
        .taken (eval_taken)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Flags, pending counter, sticky error and latched branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            z        <= 1'b0;
            v        <= 1'b0;
            n        <= 1'b0;
            pending  <= '0;
            err      <= 1'b0;
            cond_q   <= '0;
            target_q <= '0;
        end else begin
            z        <= z_nxt;
            v        <= v_nxt;
            n        <= n_nxt;
            pending  <= pending_nxt;
            err      <= err | pend_err;
            cond_q   <= cond_nxt;
            target_q <= target_nxt;
        end
    end

    // Flush down-counter: loaded when leaving EVAL taken, counts down in FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (state == ST_EVAL) begin
            flush_cnt <= 3'(FLUSH_CYC - 1);
        end else if (state == ST_FLUSH && flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    // Registered pulse outputs and redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_resolved    <= 1'b0;
            br_taken       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            br_resolved    <= (state_nxt == ST_EVAL);
            br_taken       <= (state_nxt == ST_EVAL) & eval_taken;
            redirect_valid <= (state_nxt == ST_EVAL) & eval_taken;
            if (state_nxt == ST_EVAL && eval_taken) redirect_pc <= target_nxt;
            flush          <= (state_nxt == ST_FLUSH);
        end
    end

endmodule

// File: tb/tb_branch_flag_ctrl.sv
// Self-checking bench for branch_flag_ctrl: directed scenarios followed by
// randomized branches checked against a transaction-level flag model.
module tb_branch_flag_ctrl;
    import branch_flag_ctrl_pkg::*;

    localparam int PC_W      = 16;
    localparam int MAX_PEND  = 3;
    localparam int FLUSH_CYC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flag_wr_issue, flag_wr_valid;
    logic            nxt_z, nxt_v, nxt_n;
    logic            br_valid, br_ready;
    logic [3:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            br_resolved, br_taken, stall, flush, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int m_pend;
    bit m_z, m_v, m_n, m_err;

    branch_flag_ctrl #(.PC_W(PC_W), .MAX_PEND(MAX_PEND), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst(rst),
        .flag_wr_issue(flag_wr_issue), .flag_wr_valid(flag_wr_valid),
        .nxt_z(nxt_z), .nxt_v(nxt_v), .nxt_n(nxt_n),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .br_resolved(br_resolved), .br_taken(br_taken),
        .stall(stall), .flush(flush), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [3:0] c, input bit z, input bit v, input bit n);
        case (c[2:0])
            3'd0: return z;
            3'd1: return !z;
            3'd2: return !z && !n && !v;
            3'd3: return n && !v;
            3'd4: return !n && !v;
            3'd5: return (n && !v) || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Apply the model for the currently driven inputs, then advance one edge.
    task automatic cyc();
        if (rst) begin
            m_pend = 0; m_z = 0; m_v = 0; m_n = 0; m_err = 0;
        end else begin
            if (flag_wr_valid) begin
                m_z = nxt_z; m_v = nxt_v; m_n = nxt_n;
            end
            if (flag_wr_issue && !flag_wr_valid) begin
                if (m_pend == MAX_PEND) m_err = 1; else m_pend++;
            end
            if (!flag_wr_issue && flag_wr_valid) begin
                if (m_pend == 0) m_err = 1; else m_pend--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Called on the first expected flush cycle; measures flush length.
    task automatic run_flush(input string tag);
        int cnt;
        cnt = 0;
        while (flush === 1'b1 && cnt < 12) begin
            cnt++;
            cyc();
        end
        check({tag, "_flush_len"}, cnt, FLUSH_CYC);
        check({tag, "_ready_after"}, br_ready, 1'b1);
    endtask

    logic [3:0]      r_cond;
    logic [PC_W-1:0] r_tgt;
    int              k, gap;
    bit              exp_t;

    initial begin
        rst = 1'b1; flag_wr_issue = 0; flag_wr_valid = 0;
        nxt_z = 0; nxt_v = 0; nxt_n = 0;
        br_valid = 0; br_cond = '0; br_target = '0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        check("rst_ready", br_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_flush", flush, 0);
        check("rst_resolved", br_resolved, 0);
        check("rst_redir", redirect_valid, 0);
        check("rst_pc", redirect_pc, 0);
        check("rst_err", err, 0);
        check("rst_pend", dut.pending, 0);

        // EQUAL with z = 0, no pending writers: not taken
        br_valid = 1; br_cond = 4'h0; br_target = 16'h1234;
        cyc(); br_valid = 0;
        check("t1_resolved", br_resolved, 1);
        check("t1_taken", br_taken, ref_taken(4'h0, m_z, m_v, m_n));
        check("t1_redir", redirect_valid, 0);
        check("t1_stall", stall, 1);
        cyc();
        check("t1_idle_ready", br_ready, 1);
        check("t1_idle_res", br_resolved, 0);
        check("t1_idle_flush", flush, 0);

        // z set by a retiring writer, EQUAL taken to 0x0040
        flag_wr_issue = 1; cyc(); flag_wr_issue = 0;
        flag_wr_valid = 1; nxt_z = 1; cyc(); flag_wr_valid = 0; nxt_z = 0;
        br_valid = 1; br_cond = 4'h0; br_target = 16'h0040;
        cyc(); br_valid = 0;
        check("t2_redir", redirect_valid, 1);
        check("t2_pc", redirect_pc, 16'h0040);
        check("t2_taken", br_taken, 1);
        cyc();
        check("t2_redir_pulse", redirect_valid, 0);
        run_flush("t2");

        // Two pending writers, LESS waits for both retirements
        flag_wr_issue = 1; cyc(); cyc(); flag_wr_issue = 0;
        br_valid = 1; br_cond = 4'h3; br_target = 16'h0100;
        cyc(); br_valid = 0;
        check("t3_c1_stall", stall, 1); check("t3_c1_res", br_resolved, 0); cyc();
        check("t3_c2_stall", stall, 1); cyc();
        flag_wr_valid = 1; nxt_z = 0; nxt_v = 0; nxt_n = 0;
        check("t3_c3_stall", stall, 1); cyc(); flag_wr_valid = 0;
        check("t3_c4_res", br_resolved, 0); cyc();
        flag_wr_valid = 1; nxt_n = 1;
        check("t3_c5_stall", stall, 1); cyc(); flag_wr_valid = 0; nxt_n = 0;
        check("t3_c6_res", br_resolved, 1);
        check("t3_c6_taken", br_taken, ref_taken(4'h3, m_z, m_v, m_n));
        cyc();
        run_flush("t3");

        // Same-cycle issue and retire keeps pending, loads flags
        flag_wr_issue = 1; cyc();
        flag_wr_valid = 1; nxt_z = 1; cyc();
        flag_wr_issue = 0; flag_wr_valid = 0; nxt_z = 0;
        check("t4_pend", dut.pending, m_pend);
        check("t4_z", dut.z, m_z);
        check("t4_err", err, m_err);
        br_valid = 1; br_cond = 4'h0; br_target = 16'h0200;
        cyc(); br_valid = 0;
        check("t4_wait_stall", stall, 1);
        check("t4_wait_res", br_resolved, 0);
        flag_wr_valid = 1; nxt_z = 1; cyc(); flag_wr_valid = 0; nxt_z = 0;
        check("t4_res", br_resolved, 1);
        check("t4_taken", br_taken, ref_taken(4'h0, m_z, m_v, m_n));
        check("t4_pc", redirect_pc, 16'h0200);
        cyc();
        run_flush("t4");

        // Overflow and underflow set the sticky error
        flag_wr_issue = 1; repeat (4) cyc(); flag_wr_issue = 0;
        check("t5_err_ovf", err, m_err);
        check("t5_pend_sat", dut.pending, m_pend);
        cyc();
        check("t5_err_sticky", err, 1);
        flag_wr_valid = 1; repeat (3) cyc();
        check("t5_pend_zero", dut.pending, 0);
        nxt_v = 1; cyc(); flag_wr_valid = 0; nxt_v = 0;
        check("t5_pend_under", dut.pending, m_pend);
        check("t5_err_under", err, 1);
        check("t5_v_loaded", dut.v, m_v);

        // Reset mid-flush abandons the branch
        rst = 1; cyc(); rst = 0;
        check("t6_err_clr", err, 0);
        flag_wr_issue = 1; cyc(); flag_wr_issue = 0;
        flag_wr_valid = 1; nxt_z = 1; cyc(); flag_wr_valid = 0; nxt_z = 0;
        br_valid = 1; br_cond = 4'hF; br_target = 16'h0ABC;
        cyc(); br_valid = 0;
        check("t6_taken", br_taken, 1);
        cyc();
        check("t6_flush1", flush, 1);
        rst = 1; flag_wr_issue = 1; cyc(); rst = 0; flag_wr_issue = 0;
        check("t6_flush", flush, 0);
        check("t6_stall", stall, 0);
        check("t6_pend", dut.pending, 0);
        check("t6_z", dut.z, 0);
        check("t6_ready", br_ready, 1);
        check("t6_redir", redirect_valid, 0);

        // Randomized branches with random retirement timing and flags
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, MAX_PEND);
            flag_wr_issue = 1; repeat (k) cyc(); flag_wr_issue = 0;
            r_cond = 4'($urandom); r_tgt = 16'($urandom);
            br_valid = 1; br_cond = r_cond; br_target = r_tgt;
            cyc(); br_valid = 0;
            for (int r = 0; r < k; r++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    check("rnd_wait_res", br_resolved, 0);
                    cyc();
                end
                flag_wr_valid = 1; {nxt_z, nxt_v, nxt_n} = 3'($urandom);
                check("rnd_wait_stall", stall, 1);
                cyc(); flag_wr_valid = 0;
            end
            exp_t = ref_taken(r_cond, m_z, m_v, m_n);
            check("rnd_res", br_resolved, 1);
            check("rnd_taken", br_taken, exp_t);
            check("rnd_redir", redirect_valid, exp_t);
            if (exp_t) check("rnd_pc", redirect_pc, r_tgt);
            cyc();
            if (exp_t) run_flush("rnd");
            else check("rnd_ready", br_ready, 1);
        end
        check("final_err", err, m_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
